pattern_sequencer: RTL and testbench

Command sequencer that sits between the UART receiver and the VGA pattern generator. It decodes received ASCII command bytes and commits colour changes only on a frame boundary, so a change never tears mid-frame. It also provides an auto-cycle mode that steps red, green, blue, red, and so on every FRAMES_PER_STEP frames. Its Keystroke_Out drives the pattern generator's Keystroke input directly.

---
 rtl/pattern_sequencer.sv | 98 +++++++++
 tb/tb_pattern_sequencer.sv | 127 ++++++++++++
 2 files changed

// File: rtl/pattern_sequencer.sv
// pattern_sequencer: decodes UART colour commands and commits them on frame boundaries, with an auto-cycle mode.
module pattern_sequencer #(
  parameter int FRAMES_PER_STEP = 60
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Rx_DV,
  input  logic [7:0] Rx_Byte,
  input  logic       Frame_Start,
  output logic [7:0] Keystroke_Out,
  output logic       Auto_Active,
  output logic       Pending
);
  typedef enum logic [1:0] {MANUAL, PEND, AUTO} state_t;
  state_t     r_state, w_state;
  logic [7:0] r_key, w_key, r_cnt, w_cnt, r_code, w_code;
  logic       r_pauto, w_pauto, r_pexit, w_pexit, r_pstop, w_pstop;
  logic       r_auto, r_pend;
  logic       w_dig, w_wrap;
  assign w_dig  = Rx_Byte[7:2] == 6'b001100;
  assign w_wrap = r_cnt == 8'(FRAMES_PER_STEP - 1);
  // Frame commit is resolved first; a byte arriving in the same cycle is then applied to the post-commit state.
  always_comb begin
    w_state = r_state;
    w_key   = r_key;
    w_cnt   = r_cnt;
    w_code  = r_code;
    w_pauto = r_pauto;
    w_pexit = r_pexit;
    w_pstop = r_pstop;
    if (Frame_Start) begin
      case (r_state)
        PEND: begin
          w_state = r_pauto ? AUTO : MANUAL;
          w_key   = r_pauto ? 8'h31 : r_code;
          w_cnt   = 8'd0;
        end
        AUTO: begin
          if (r_pexit || r_pstop) begin
            w_state = MANUAL;
            w_key   = r_pexit ? r_code : r_key;
          end else begin
            w_cnt = w_wrap ? 8'd0 : r_cnt + 8'd1;
            w_key = !w_wrap ? r_key : (r_key == 8'h33) ? 8'h31 : r_key + 8'd1;
          end
        end
        default: ;
      endcase
      w_pauto = 1'b0;
      w_pexit = 1'b0;
      w_pstop = 1'b0;
    end
    if (Rx_DV) begin
      if (w_dig) begin
        w_code = Rx_Byte;
        if (w_state == AUTO) begin
          w_pexit = 1'b1;
          w_pstop = 1'b0;
        end else begin
          w_state = PEND;
          w_pauto = 1'b0;
        end
      end else if (Rx_Byte == 8'h61 && w_state != AUTO) begin
        w_state = PEND;
        w_pauto = 1'b1;
      end else if (Rx_Byte == 8'h73 && w_state == AUTO) begin
        w_pstop = 1'b1;
        w_pexit = 1'b0;
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= MANUAL;
      r_key   <= 8'h30;
      r_cnt   <= 8'd0;
      r_code  <= 8'h30;
      r_pauto <= 1'b0;
      r_pexit <= 1'b0;
      r_pstop <= 1'b0;
      r_auto  <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_key   <= w_key;
      r_cnt   <= w_cnt;
      r_code  <= w_code;
      r_pauto <= w_pauto;
      r_pexit <= w_pexit;
      r_pstop <= w_pstop;
      r_auto  <= w_state == AUTO;
      r_pend  <= w_state == PEND || (w_state == AUTO && (w_pexit || w_pstop));
    end
  end
  assign Keystroke_Out = r_key;
  assign Auto_Active   = r_auto;
  assign Pending       = r_pend;
endmodule

// File: tb/tb_pattern_sequencer.sv
// tb_pattern_sequencer: directed and random checks against a frame-level behavioural model.
module tb_pattern_sequencer;
  localparam int F = 3;
  logic       CLK = 1'b0, RST = 1'b1, Rx_DV = 1'b0, Frame_Start = 1'b0;
  logic [7:0] Rx_Byte = 8'h00;
  logic [7:0] Keystroke_Out;
  logic       Auto_Active, Pending;
  int         n_chk = 0, n_fail = 0;
  logic [7:0] m_key, m_pend;
  logic       m_auto;
  int         m_afr;
  pattern_sequencer #(.FRAMES_PER_STEP(F)) dut (
    .CLK(CLK), .RST(RST), .Rx_DV(Rx_DV), .Rx_Byte(Rx_Byte), .Frame_Start(Frame_Start),
    .Keystroke_Out(Keystroke_Out), .Auto_Active(Auto_Active), .Pending(Pending)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic model_step(input logic fs, input logic dv, input logic [7:0] b);
    if (fs) begin
      if (m_pend == 8'h61) begin
        m_auto = 1'b1; m_afr = 0; m_key = 8'h31;
      end else if (m_pend == 8'h73) begin
        m_auto = 1'b0;
      end else if (m_pend != 8'h00) begin
        m_auto = 1'b0; m_key = m_pend;
      end else if (m_auto) begin
        m_afr++;
        m_key = 8'h31 + 8'((m_afr / F) % 3);
      end
      m_pend = 8'h00;
    end
    if (dv) begin
      if (b >= 8'h30 && b <= 8'h33) m_pend = b;
      else if (b == 8'h61 && !m_auto) m_pend = b;
      else if (b == 8'h73 && m_auto) m_pend = b;
    end
  endtask
  task automatic cyc(input logic rst, input logic fs, input logic dv, input logic [7:0] b);
    RST = rst; Frame_Start = fs; Rx_DV = dv; Rx_Byte = b;
    @(posedge CLK);
    if (rst) begin
      m_key = 8'h30; m_pend = 8'h00; m_auto = 1'b0; m_afr = 0;
    end else model_step(fs, dv, b);
    #1;
    chk("key", Keystroke_Out, m_key);
    chk("auto", {7'd0, Auto_Active}, {7'd0, m_auto});
    chk("pending", {7'd0, Pending}, {7'd0, m_pend != 8'h00});
    RST = 1'b0; Frame_Start = 1'b0; Rx_DV = 1'b0; Rx_Byte = 8'h00;
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 8'h00);
  endtask
  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      idle(2);
    end
  endtask
  task automatic send(input logic [7:0] b);
    cyc(1'b0, 1'b0, 1'b1, b);
  endtask
  initial begin
    logic [7:0] pool [7];
    logic [7:0] b;
    pool = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h61, 8'h73, 8'h7A};
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    chk("reset_key", Keystroke_Out, 8'h30);
    frames(3);
    chk("reset_frames_key", Keystroke_Out, 8'h30);
    idle(7);
    send(8'h32);
    idle(39);
    chk("manual_wait_key", Keystroke_Out, 8'h30);
    chk("manual_wait_pend", {7'd0, Pending}, 8'd1);
    frames(1);
    chk("manual_commit_key", Keystroke_Out, 8'h32);
    chk("manual_commit_pend", {7'd0, Pending}, 8'd0);
    send(8'h31); send(8'h7A); send(8'h33);
    frames(1);
    chk("last_wins", Keystroke_Out, 8'h33);
    send(8'h61);
    frames(1);
    chk("auto_p1", Keystroke_Out, 8'h31);
    chk("auto_p1_active", {7'd0, Auto_Active}, 8'd1);
    frames(3);
    chk("auto_p4", Keystroke_Out, 8'h32);
    frames(3);
    chk("auto_p7", Keystroke_Out, 8'h33);
    frames(3);
    chk("auto_p10", Keystroke_Out, 8'h31);
    frames(3);
    frames(2);
    send(8'h73);
    frames(1);
    chk("stop_key", Keystroke_Out, 8'h32);
    chk("stop_active", {7'd0, Auto_Active}, 8'd0);
    send(8'h61);
    frames(4);
    send(8'h30);
    frames(1);
    chk("exit_digit_key", Keystroke_Out, 8'h30);
    chk("exit_digit_active", {7'd0, Auto_Active}, 8'd0);
    send(8'h31);
    cyc(1'b0, 1'b1, 1'b1, 8'h33);
    chk("collide_key", Keystroke_Out, 8'h31);
    chk("collide_pend", {7'd0, Pending}, 8'd1);
    frames(1);
    chk("collide_next", Keystroke_Out, 8'h33);
    send(8'h32);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    frames(2);
    chk("reset_drop", Keystroke_Out, 8'h30);
    for (int i = 0; i < 3000; i++) begin
      b = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 6)];
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, b);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
